// File: rtl/gate_pkg.sv
// Shared definitions for the two-input gate exerciser and its reference model.
package gate_pkg;

  localparam logic [1:0] GATE_AND  = 2'd0;
  localparam logic [1:0] GATE_OR   = 2'd1;
  localparam logic [1:0] GATE_XOR  = 2'd2;
  localparam logic [1:0] GATE_NAND = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Truth function of the modelled gate.
  function automatic logic gate_eval(input logic [1:0] op, input logic a, input logic b);
    logic y;
    case (op)
      GATE_AND:  y = a & b;
      GATE_OR:   y = a | b;
      GATE_XOR:  y = a ^ b;
      default:   y = ~(a & b);
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational expected-value generator for a two-input gate.
module gate_ref_model
  import gate_pkg::*;
(
  input  logic [1:0] i_op,
  input  logic       i_a,
  input  logic       i_b,
  output logic       o_y
);

  assign o_y = gate_eval(i_op, i_a, i_b);

endmodule

// File: rtl/gate_exerciser.sv
// Drives every a/b combination REPEAT times into a registered gate and
// checks y two cycles after each vector is driven.
module gate_exerciser
  import gate_pkg::*;
#(
  parameter int OP     = 0,
  parameter int REPEAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count
);

  localparam int             N       = 4 * REPEAT;
  localparam int             KW      = $clog2(N);
  localparam logic [1:0]     OP_CODE = OP[1:0];
  localparam logic [KW-1:0]  K_LAST  = KW'(N - 1);

  generate
    if (OP < 0 || OP > 3) begin : g_bad_op
      $error("gate_exerciser: OP must be 0..3");
    end
    if (REPEAT < 1 || REPEAT > 1024) begin : g_bad_repeat
      $error("gate_exerciser: REPEAT must be 1..1024");
    end
  endgenerate

  state_t        r_state;
  state_t        w_next;
  logic [KW-1:0] r_k;
  logic          r_flush;
  logic [1:0]    r_vld;
  logic [1:0]    r_exp;
  logic          w_exp;
  logic          w_last;

  assign w_last = (r_k == K_LAST);

  // Expected value for the vector about to be driven (k mod 4 = {a,b}).
  gate_ref_model u_ref (
    .i_op (OP_CODE),
    .i_a  (r_k[1]),
    .i_b  (r_k[0]),
    .o_y  (w_exp)
  );

  // Next-state selection; start only matters in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FLUSH;
      S_FLUSH: if (r_flush) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Vector drive, 2-stage check pipeline and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 8'd0;
      r_k       <= '0;
      r_flush   <= 1'b0;
      r_vld     <= 2'b00;
      r_exp     <= 2'b00;
    end else begin
      done  <= 1'b0;
      a_out <= 1'b0;
      b_out <= 1'b0;
      r_vld <= {r_vld[0], 1'b0};
      r_exp <= {r_exp[0], 1'b0};
      // Stage 2 lines up with the gate's registered response.
      if (r_vld[1] && (y_in != r_exp[1]) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            err_count <= 8'd0;
            pass      <= 1'b0;
            r_k       <= '0;
          end
        end
        S_RUN: begin
          busy           <= 1'b1;
          {a_out, b_out} <= r_k[1:0];
          r_vld[0]       <= 1'b1;
          r_exp[0]       <= w_exp;
          r_k            <= w_last ? '0 : r_k + 1'b1;
          r_flush        <= 1'b0;
        end
        S_FLUSH: begin
          r_flush <= 1'b1;
        end
        S_DONE: begin
          // The final check landed on the previous edge, so err_count is final here.
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (err_count == 8'd0);
          r_flush <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: three instances (AND x4, OR x4, AND x100) each
// driving a behavioural gate whose truth table the bench chooses per run.
module tb_gate_exerciser;
  import gate_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [2:0] y;
  logic [2:0] a, b, busy, done, pass;
  logic [7:0] err [3];
  logic [3:0] tt  [3];

  int ops  [3] = '{0, 1, 0};
  int reps [3] = '{4, 4, 100};
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_exerciser #(.OP(0), .REPEAT(4)) u_and (
    .clk(clk), .rst(rst), .start(start[0]), .y_in(y[0]),
    .a_out(a[0]), .b_out(b[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err[0]));

  gate_exerciser #(.OP(1), .REPEAT(4)) u_or (
    .clk(clk), .rst(rst), .start(start[1]), .y_in(y[1]),
    .a_out(a[1]), .b_out(b[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err[1]));

  gate_exerciser #(.OP(0), .REPEAT(100)) u_sat (
    .clk(clk), .rst(rst), .start(start[2]), .y_in(y[2]),
    .a_out(a[2]), .b_out(b[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .err_count(err[2]));

  // Gate under test: registered lookup into a bench-chosen truth table.
  always @(posedge clk)
    for (int i = 0; i < 3; i++) y[i] <= tt[i][{a[i], b[i]}];

  function automatic int model_bit(input int op, input int v);
    int av, bv;
    av = (v >> 1) & 1;
    bv = v & 1;
    case (op)
      0:       return av & bv;
      1:       return av | bv;
      2:       return av ^ bv;
      default: return 1 - (av & bv);
    endcase
  endfunction

  // Each pass over the 4 vectors mismatches once per differing truth-table entry.
  function automatic int exp_err(input int op, input logic [3:0] t, input int rep);
    int n = 0;
    for (int v = 0; v < 4; v++)
      if (int'(t[v]) != model_bit(op, v)) n += rep;
    return (n > 255) ? 255 : n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One start pulse; checks vector sequence, busy window, done timing and result.
  task automatic run(input int i, input logic [3:0] t);
    int n, e, dones, busyc, abbad;
    n = 4 * reps[i];
    e = exp_err(ops[i], t, reps[i]);
    dones = 0; busyc = 0; abbad = 0;
    tt[i] = t;
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
    for (int c = 1; c <= n + 6; c++) begin
      @(posedge clk); #1;
      if (c <= n) begin
        if ({a[i], b[i]} !== 2'((c - 1) % 4)) abbad++;
      end else if ({a[i], b[i]} !== 2'b00) abbad++;
      if (c == 1) check("busy_rise", busy[i], 1);
      if (busy[i] === 1'b1) busyc++;
      if (done[i] === 1'b1) begin
        dones++;
        check("done_time", c, n + 3);
        check("busy_at_done", busy[i], 0);
        check("err_count", err[i], e);
        check("pass", pass[i], (e == 0) ? 1 : 0);
      end
    end
    check("done_pulses", dones, 1);
    check("busy_cycles", busyc, n + 2);
    check("vector_seq", abbad, 0);
    check("err_held", err[i], e);
    check("pass_held", pass[i], (e == 0) ? 1 : 0);
  endtask

  initial begin
    logic [3:0] t;
    int i, n, d1, d2;
    rst = 1'b1; start = 3'b000;
    for (int k = 0; k < 3; k++) tt[k] = 4'b1000;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_ab", {a[k], b[k]}, 0);
      check("rst_busy_done_pass", {busy[k], done[k], pass[k]}, 0);
      check("rst_err", err[k], 0);
    end
    rst = 1'b0;

    // Directed runs.
    run(0, 4'b1000);   // correct AND
    run(0, 4'b0000);   // stuck at 0
    run(0, 4'b1111);   // stuck at 1
    run(1, 4'b1000);   // OR model against AND gate
    run(2, 4'b1111);   // 300 mismatches, saturating

    // start held high through a run.
    n = 16; d1 = 0; d2 = 0;
    tt[0] = 4'b1111;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= n + 4; c++) begin
      @(posedge clk); #1;
      if (done[0] === 1'b1) begin
        d1++;
        check("hold_done_time", c, n + 3);
        check("hold_err1", err[0], 12);
      end
    end
    check("hold_restart_clr", err[0], 0);
    check("hold_restart_busy", busy[0], 0);
    check("hold_one_run", d1, 1);
    start[0] = 1'b0;
    for (int c = 1; c <= n + 6; c++) begin
      @(posedge clk); #1;
      if (done[0] === 1'b1) begin
        d2++;
        check("hold_done2_time", c, n + 3);
        check("hold_err2", err[0], 12);
      end
    end
    check("hold_second_run", d2, 1);

    // Reset at vector 7 aborts the run.
    tt[0] = 4'b1111;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("abort_err_before", err[0], 4);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_ab", {a[0], b[0]}, 0);
    check("abort_busy", busy[0], 0);
    check("abort_err", err[0], 0);
    d1 = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done[0] === 1'b1 || busy[0] === 1'b1) d1++;
    end
    check("abort_quiet", d1, 0);
    run(0, 4'b1000);

    // Random truth tables against the higher-level mismatch count.
    for (int r = 0; r < 6; r++) begin
      i = int'($urandom_range(0, 1));
      t = 4'($urandom);
      run(i, t);
    end
    t = 4'($urandom);
    run(2, t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
